// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM state type and oversampling constants for the UART receiver.
// Optional macro UART_RX_PARITY_EN adds the PARITY state.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } rx_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for the asynchronous serial line.
// Resets to 1 so an idle line never looks like a start bit.
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], i_d};
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampling UART receiver, LSB first, configurable data/stop length.
// Define UART_RX_PARITY_EN to add an even-parity bit and the o_parity_err output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_rx,
  input  logic            i_s_tick,
  output logic [DBIT-1:0] o_dout,
  output logic            o_rx_done_tick,
`ifdef UART_RX_PARITY_EN
  output logic            o_parity_err,
`endif
  output logic            o_frame_err
);

  localparam int SW = (SB_TICK > OVERSAMPLE) ? 5 : 4;
  localparam logic [SW-1:0] S_MID  = SW'(MID_SAMPLE);
  localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [2:0]    N_LAST = 3'(DBIT - 1);

  logic            rx_s;
  rx_state_e       state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [2:0]      n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic            pbit_q, pbit_d;
  logic            perr_q, perr_d;
`endif

  uart_rx_sync u_sync (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_d       (i_rx),
    .o_q       (rx_s)
  );

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbit_d  = pbit_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        // Start edge is taken on any clock, not just on a tick.
        if (!rx_s) begin
          state_d = ST_START;
          s_d     = '0;
        end
      end
      ST_START: begin
        if (i_s_tick) begin
          if (s_q == S_MID) begin
            if (!rx_s) begin
              state_d = ST_DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      ST_DATA: begin
        if (i_s_tick) begin
          if (s_q == S_BIT) begin
            b_d = {rx_s, b_q[DBIT-1:1]};
            s_d = '0;
            if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (i_s_tick) begin
          if (s_q == S_BIT) begin
            pbit_d  = rx_s;
            s_d     = '0;
            state_d = ST_STOP;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
`endif
      ST_STOP: begin
        if (i_s_tick) begin
          if (s_q == S_STOP) begin
            state_d = ST_IDLE;
            s_d     = '0;
            if (rx_s) begin
              dout_d = b_q;
              done_d = 1'b1;
`ifdef UART_RX_PARITY_EN
              perr_d = (^b_q) ^ pbit_q;
`endif
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbit_q  <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      pbit_q  <= pbit_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign o_dout         = dout_q;
  assign o_rx_done_tick = done_q;
  assign o_frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err   = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed scoreboard bench for uart_rx (8 data bits, 1 stop bit, tick every 4 clocks).
// Exercises parity frames when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  logic       i_clk = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       i_rx = 1'b1;
  logic       i_s_tick = 1'b0;
  logic [7:0] o_dout;
  logic       o_rx_done_tick;
  logic       o_frame_err;
`ifdef UART_RX_PARITY_EN
  logic       o_parity_err;
`endif

  int checks = 0;
  int errors = 0;
  int tick_div = 0;

  typedef struct packed {
    logic       is_err;
    logic       perr;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_rx           (i_rx),
    .i_s_tick       (i_s_tick),
    .o_dout         (o_dout),
    .o_rx_done_tick (o_rx_done_tick),
`ifdef UART_RX_PARITY_EN
    .o_parity_err   (o_parity_err),
`endif
    .o_frame_err    (o_frame_err)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    tick_div = (tick_div + 1) % 4;
    i_s_tick = (tick_div == 0);
  end

  // Scoreboard: every output pulse must match the oldest outstanding expectation.
  always @(negedge i_clk) begin
    exp_t e;
    if (o_rx_done_tick === 1'b1 || o_frame_err === 1'b1) begin
      checks++;
      assert (!(o_rx_done_tick && o_frame_err))
      else begin errors++; $error("FAIL pulse_exclusive done=%0b ferr=%0b required not both", o_rx_done_tick, o_frame_err); end
      checks++;
      assert (exp_q.size() != 0)
      else begin errors++; $error("FAIL unexpected_pulse done=%0b ferr=%0b dout=%02h required no pulse", o_rx_done_tick, o_frame_err, o_dout); end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        assert (o_frame_err === e.is_err)
        else begin errors++; $error("FAIL pulse_kind ferr=%0b required %0b", o_frame_err, e.is_err); end
        checks++;
        assert (o_dout === e.data)
        else begin errors++; $error("FAIL dout got %02h required %02h", o_dout, e.data); end
`ifdef UART_RX_PARITY_EN
        checks++;
        assert (o_parity_err === e.perr)
        else begin errors++; $error("FAIL parity_err got %0b required %0b", o_parity_err, e.perr); end
`endif
      end
    end
  end

  task automatic wait_ticks(input int k);
    repeat (k) begin
      do @(posedge i_clk); while (i_s_tick !== 1'b1);
    end
    #1;
  endtask

  task automatic send_bit(input logic v, input int k);
    i_rx = v;
    wait_ticks(k);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_v);
    send_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) send_bit(d[i], 16);
`ifdef UART_RX_PARITY_EN
    send_bit(par_v, 16);
`endif
    if (stop_v) begin
      send_bit(1'b1, 16);
    end else begin
      send_bit(1'b0, 10);
      send_bit(1'b1, 6);
    end
  endtask

  task automatic check_drained(input string tag);
    checks++;
    assert (exp_q.size() == 0)
    else begin errors++; $error("FAIL %s outstanding=%0d required 0", tag, exp_q.size()); end
  endtask

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] req);
    checks++;
    assert (got === req)
    else begin errors++; $error("FAIL %s got %02h required %02h", tag, got, req); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge i_clk);
    check_val("reset_dout", o_dout, 8'h00);
    check_val("reset_done", {7'd0, o_rx_done_tick}, 8'h00);
    check_val("reset_ferr", {7'd0, o_frame_err}, 8'h00);
    i_reset_n = 1'b1;
    wait_ticks(20);

    exp_q.push_back('{is_err: 1'b0, perr: 1'b0, data: 8'hA5});
    send_frame(8'hA5, 1'b1, 1'b0);
    wait_ticks(20);
    check_drained("frame_a5");

    i_rx = 1'b0;
    wait_ticks(5);
    i_rx = 1'b1;
    wait_ticks(30);
    check_drained("glitch");
    check_val("glitch_dout", o_dout, 8'hA5);

    exp_q.push_back('{is_err: 1'b1, perr: 1'b0, data: 8'hA5});
    send_frame(8'h3C, 1'b0, 1'b0);
    wait_ticks(30);
    check_drained("frame_err_3c");
    check_val("ferr_dout_kept", o_dout, 8'hA5);

    exp_q.push_back('{is_err: 1'b0, perr: 1'b0, data: 8'h00});
    exp_q.push_back('{is_err: 1'b0, perr: 1'b0, data: 8'hFF});
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    wait_ticks(20);
    check_drained("back_to_back");
    check_val("b2b_dout", o_dout, 8'hFF);

    send_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) send_bit(1'b1 ^ i[0], 16);
    i_rx = 1'b1;
    wait_ticks(8);
    #2;
    i_reset_n = 1'b0;
    #1;
    check_val("midreset_dout", o_dout, 8'h00);
    check_val("midreset_done", {7'd0, o_rx_done_tick}, 8'h00);
    check_val("midreset_ferr", {7'd0, o_frame_err}, 8'h00);
    repeat (3) @(negedge i_clk);
    i_reset_n = 1'b1;
    wait_ticks(20);
    check_drained("midreset_discard");

    exp_q.push_back('{is_err: 1'b0, perr: 1'b0, data: 8'h81});
    send_frame(8'h81, 1'b1, 1'b0);
    wait_ticks(20);
    check_drained("frame_81");
    check_val("frame_81_dout", o_dout, 8'h81);

`ifdef UART_RX_PARITY_EN
    exp_q.push_back('{is_err: 1'b0, perr: 1'b1, data: 8'h07});
    send_frame(8'h07, 1'b1, 1'b0);
    wait_ticks(20);
    check_drained("parity_07");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DBIT, default 8, number of data bits per frame (5..8).
REQ-002 SHALL have parameter SB_TICK, default 16, oversampling ticks per stop bit (16 = 1 stop, 24 = 1.5, 32 = 2).
REQ-003 SHALL have port i_clk, input, 1, system clock, all state on rising edge.
REQ-004 SHALL have port i_reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port i_rx, input, 1, serial line (idle high), asynchronous to i_clk.
REQ-006 SHALL have port i_s_tick, input, 1, one-cycle 16x-oversampling enable from the baud-rate tick counter.
REQ-007 SHALL have port o_dout, output, DBIT, last received data word, LSB received first.
REQ-008 SHALL have port o_rx_done_tick, output, 1, one-cycle pulse: o_dout valid and new.
REQ-009 SHALL have port o_frame_err, output, 1, one-cycle pulse: stop bit sampled low.

Function
REQ-010 SHALL pass i_rx through a 2-flop synchronizer (reset value 1); all FSM decisions use the synchronized value rx_s.
REQ-011 SHALL implement FSM states IDLE, START, DATA, STOP (plus PARITY under REQ-024); tick counter s (4 bits, 5 bits if SB_TICK > 16), bit counter n (3 bits).
REQ-012 IDLE: rx_s == 0 -> START, s = 0; i_s_tick is not required for this transition.
REQ-013 START: on i_s_tick with s == 7: rx_s == 0 -> DATA, s = 0, n = 0; rx_s == 1 -> IDLE (glitch reject, no output pulse); otherwise s increments on i_s_tick.
REQ-014 DATA: on i_s_tick with s == 15: shift rx_s into MSB of shift register b (right shift), s = 0; if n == DBIT-1 -> STOP, else n increments.
REQ-015 STOP: on i_s_tick with s == SB_TICK-1 -> IDLE; rx_s == 1 -> o_dout <= b and o_rx_done_tick = 1; rx_s == 0 -> o_frame_err = 1, o_dout unchanged.
REQ-016 Counters SHALL advance only in cycles with i_s_tick == 1; cycles without a tick hold all state.
REQ-017 o_rx_done_tick and o_frame_err SHALL be registered, high exactly one i_clk cycle after the completing tick, and never high together.
REQ-018 o_dout SHALL hold its value until the next error-free frame completes.
REQ-019 Continued low line after a framing error (break) SHALL re-enter START from IDLE; no special break handling.
REQ-020 Back-to-back frames SHALL be accepted: IDLE detects the next start edge in the cycle after returning.

Reset
REQ-021 i_reset_n low SHALL force FSM to IDLE, s = 0, n = 0, b = 0, o_dout = 0, o_rx_done_tick = 0, o_frame_err = 0, synchronizer flops = 1, immediately and regardless of clock.
REQ-022 Reset asserted mid-frame SHALL discard the partial frame with no output pulse; after release, reception restarts on the next falling edge.

Configuration
REQ-023 Macro UART_RX_PARITY_EN SHALL compile in even-parity support; absent it, no PARITY state and no o_parity_err port exist.
REQ-024 With UART_RX_PARITY_EN: DATA -> PARITY after the last data bit; PARITY samples at s == 15, then -> STOP; output o_parity_err (1 bit, reset 0) pulses with o_rx_done_tick when XOR(b, parity bit) == 1; o_dout is still updated.

Structure
REQ-025 Package uart_pkg SHALL hold the FSM state enum, OVERSAMPLE = 16 and MID_SAMPLE = 7 constants.
REQ-026 Synchronizer SHALL be sub-module uart_rx_sync (2 flops, active-low async reset to 1).

Verification
REQ-027 Frame 0xA5 (LSB first), 1 stop, tick every 4 clocks -> one o_rx_done_tick, o_dout = 0xA5, o_frame_err = 0.
REQ-028 Low pulse of 5 ticks on idle line -> FSM back to IDLE, no pulses, o_dout unchanged.
REQ-029 Frame 0x3C with stop bit forced low -> o_frame_err pulse, no o_rx_done_tick, o_dout keeps prior 0xA5.
REQ-030 Frames 0x00 then 0xFF with zero idle gap -> two done pulses, o_dout 0x00 then 0xFF.
REQ-031 i_reset_n low during data bit 4 of 0x55 -> all outputs 0 at once; next frame 0x81 received correctly.
REQ-032 UART_RX_PARITY_EN defined, frame 0x07 with parity bit 0 -> o_rx_done_tick with o_parity_err = 1, o_dout = 0x07.
